// File: rtl/ee457_instr_encoder.sv
// ee457_instr_encoder: encodes MIPS-subset instruction fields into words and loads them into instruction memory
module ee457_instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        last,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        done,
  output logic        cpu_run,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [5:0]  op, func;
  logic        shift, jr, legal;
  logic [31:0] enc;
  always_comb begin
    op = 6'd0;
    func = 6'd0;
    case (mnem)
      5'd0:  func = 6'b100000;
      5'd1:  func = 6'b100010;
      5'd2:  func = 6'b100100;
      5'd3:  func = 6'b100101;
      5'd4:  func = 6'b100110;
      5'd5:  func = 6'b100111;
      5'd6:  func = 6'b101010;
      5'd7:  func = 6'b000000;
      5'd8:  func = 6'b000010;
      5'd9:  func = 6'b000011;
      5'd10: func = 6'b001000;
      5'd11: op = 6'b100011;
      5'd12: op = 6'b101011;
      5'd13: op = 6'b000100;
      5'd14: op = 6'b000101;
      5'd15: op = 6'b001000;
      5'd16: op = 6'b000010;
      5'd17: op = 6'b000011;
      default: ;
    endcase
    shift = mnem inside {5'd7, 5'd8, 5'd9};
    jr = mnem == 5'd10;
    legal = mnem < 5'd18;
    // R-type fields that the instruction does not use are forced to zero
    enc = mnem <= 5'd10 ? {6'd0, shift ? 5'd0 : rs, jr ? 5'd0 : rt, jr ? 5'd0 : rd, shift ? shamt : 5'd0, func}
        : mnem <= 5'd15 ? {op, rs, rt, imm}
        : {op, target};
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    word_d = word_q;
    last_d = last_q;
    err_d = err_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        addr_d = 8'd0;
        err_d = 1'b0;
      end
      LOAD: if (in_valid) begin
        if (legal) begin
          state_d = WRITE;
          word_d = enc;
          last_d = last;
        end else err_d = 1'b1;
      end
      WRITE: if (last_q || addr_q == 8'hFF) state_d = DONE;
      else begin
        state_d = LOAD;
        addr_d = addr_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= 8'd0;
      word_q <= 32'd0;
      last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      word_q <= word_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign imem_we = state_q == WRITE;
  assign imem_addr = addr_q;
  assign imem_wdata = word_q;
  assign done = state_q == DONE;
  assign cpu_run = state_q == DONE;
  assign err = err_q;
endmodule

// File: tb/tb_ee457_instr_encoder.sv
// tb_ee457_instr_encoder: directed vectors with a write scoreboard for ee457_instr_encoder
module tb_ee457_instr_encoder;
  logic clk = 1'b0;
  logic rst_n, start = 1'b0, in_valid = 1'b0, last = 1'b0;
  logic [4:0] mnem = 5'd0, rs = 5'd0, rt = 5'd0, rd = 5'd0, shamt = 5'd0;
  logic [15:0] imm = 16'd0;
  logic [25:0] target = 26'd0;
  logic in_ready, imem_we, done, cpu_run, err;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [39:0] exp_q[$];
  logic [7:0] exp_addr = 8'd0;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  ee457_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .last(last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .cpu_run(cpu_run), .err(err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("write_addr", {24'd0, imem_addr}, {24'd0, e[39:32]});
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 8'd0;
  endtask
  task automatic send(input logic [4:0] m, a, b, c, s, input logic [15:0] i, input logic [25:0] t,
                      input logic l, input logic [31:0] w);
    int k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    mnem = m; rs = a; rt = b; rd = c; shamt = s; imm = i; target = t; last = l;
    in_valid = 1'b1;
    if (m < 5'd18) begin
      exp_q.push_back({exp_addr, w});
      exp_addr++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("done", {31'd0, done}, 32'd1);
    check("cpu_run", {31'd0, cpu_run}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_done", {30'd0, done, cpu_run}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    check("load_ready", {31'd0, in_ready}, 32'd1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1, 32'h00221820);
    wait_done();
    check("done_addr", {24'd0, imem_addr}, 32'd0);
    pulse_start();
    check("restart_run", {31'd0, cpu_run}, 32'd0);
    check("restart_addr", {24'd0, imem_addr}, 32'd0);
    send(5'd11, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b0, 32'h8C080004);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    send(5'd14, 5'd8, 5'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0, 32'h1500FFFF);
    send(5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000010, 1'b1, 32'h08000010);
    wait_done();
    check("stream_addr", {24'd0, imem_addr}, 32'd2);
    mnem = 5'd0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("done_hold", {31'd0, done}, 32'd1);
    pulse_start();
    send(5'd20, 5'd1, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1'b0, 32'd0);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_stay", {31'd0, in_ready}, 32'd1);
    check("illegal_addr", {24'd0, imem_addr}, 32'd0);
    send(5'd7, 5'd7, 5'd2, 5'd4, 5'd3, 16'd0, 26'd0, 1'b1, 32'h000220C0);
    wait_done();
    check("err_sticky", {31'd0, err}, 32'd1);
    pulse_start();
    check("err_clear", {31'd0, err}, 32'd0);
    for (int i = 0; i < 256; i++)
      send(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, i[15:0], 26'd0, 1'b0, 32'h20220000 | i);
    wait_done();
    check("cap_addr", {24'd0, imem_addr}, 32'd255);
    mnem = 5'd0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    pulse_start();
    send(5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0, 32'h00210822);
    check("we_before_rst", {31'd0, imem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_we_async", {31'd0, imem_we}, 32'd0);
    check("rst_ready_async", {31'd0, in_ready}, 32'd0);
    check("rst_addr_async", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata_async", imem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {31'd0, in_ready}, 32'd0);
    pulse_start();
    send(5'd10, 5'd31, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 32'h03E00008);
    send(5'd9, 5'd9, 5'd10, 5'd11, 5'd31, 16'd0, 26'd0, 1'b0, 32'h000A5FC3);
    send(5'd12, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 26'd0, 1'b0, 32'hAFBF0008);
    send(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF, 1'b0, 32'h0FFFFFFF);
    send(5'd4, 5'd3, 5'd4, 5'd5, 5'd9, 16'd0, 26'd0, 1'b1, 32'h00642826);
    wait_done();
    check("reload_addr", {24'd0, imem_addr}, 32'd4);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ee457_instr_encoder.md
EE457_INSTR_ENCODER -- requirements
Module: ee457_instr_encoder

Interface
REQ-001 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 Port start, input, 1: one-cycle pulse that begins a program load at word address 0.
REQ-004 Port in_valid, input, 1: instruction fields are valid.
REQ-005 Port in_ready, output, 1: encoder can accept fields this cycle.
REQ-006 Port mnem, input, 5: instruction selector, see REQ-014.
REQ-007 Ports rs/rt/rd/shamt, input, 5 each: register numbers and shift amount.
REQ-008 Ports imm (input, 16) and target (input, 26): immediate and jump target fields.
REQ-009 Port last, input, 1: the presented instruction is the final one of the program.
REQ-010 Ports imem_we (output, 1), imem_addr (output, 8), imem_wdata (output, 32): instruction-memory word write port.
REQ-011 Ports done (output, 1), cpu_run (output, 1), err (output, 1): load complete, CPU release, and sticky illegal-mnemonic flag.

Function
REQ-012 The state machine SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-013 Transitions SHALL be:
- IDLE -> LOAD on start.
- LOAD -> WRITE on in_valid & in_ready with a legal mnem.
- WRITE -> DONE if the latched last=1 or imem_addr=255; otherwise WRITE -> LOAD.
- DONE -> LOAD on start.
REQ-014 mnem encodings SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA, 10 JR, 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 ADDI, 16 J, 17 JAL. Values 18-31 are illegal.
REQ-015 R-type words SHALL be 000000|rs|rt|rd|shamt|func, with func as follows:
- ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010.
- SLL 000000, SRL 000010, SRA 000011.
- JR 001000.
REQ-016 Field forcing for R-type: shamt SHALL be 0 except for SLL/SRL/SRA; rs SHALL be 0 for shifts; rt, rd and shamt SHALL be 0 for JR.
REQ-017 I-type words SHALL be op|rs|rt|imm, with op LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000.
REQ-018 J-type words SHALL be op|target, with op J 000010, JAL 000011.
REQ-019 in_ready SHALL be 1 only in LOAD.
REQ-020 The encoded word and last SHALL be registered on acceptance.
REQ-021 imem_we SHALL be 1 for exactly one cycle, in WRITE, with imem_wdata holding the registered word.
REQ-022 Latency from the acceptance edge to imem_we high SHALL be 1 cycle; sustained throughput SHALL be 1 word per 2 cycles.
REQ-023 imem_addr SHALL increment by 1 on leaving WRITE for LOAD, SHALL hold at 255 on reaching DONE (no wrap), and SHALL clear to 0 on start.
REQ-024 An illegal mnem presented with in_valid in LOAD SHALL be consumed without a write, SHALL set err, and the FSM SHALL remain in LOAD with imem_addr unchanged.
REQ-025 err SHALL clear only on reset or start.
REQ-026 done and cpu_run SHALL both be 1 exactly while in DONE, and SHALL drop the cycle after start is sampled in DONE.
REQ-027 start SHALL be ignored in LOAD and WRITE.
REQ-028 in_valid SHALL be ignored outside LOAD.

Reset
REQ-029 On rst_n low, without waiting for clk, the block SHALL immediately enter IDLE and drive in_ready, imem_we, done, cpu_run and err to 0, imem_addr to 0, and imem_wdata to 0.
REQ-030 Reset asserted mid-load SHALL abandon the load with no further writes; a new start is required after release.
REQ-031 The first start SHALL be honoured no earlier than the first clk edge after rst_n rises.

Verification
REQ-032 Single ADD: start, then ADD rs=1 rt=2 rd=3, last=1 -> one write addr 0 data 0x00221820, then done=1 and cpu_run=1.
REQ-033 Three-instruction stream: LW rs=0 rt=8 imm=4; BNE rs=8 rt=0 imm=0xFFFF; J target=0x0000010 with last=1 -> addrs 0/1/2 with data 0x8C080004, 0x1500FFFF, 0x08000010.
REQ-034 Illegal input: mnem=20 followed by SLL rt=2 rd=4 shamt=3 rs=7 -> err=1, single write addr 0 data 0x000220C0.
REQ-035 Capacity: 256 legal words with last=0 -> final write at addr 255, DONE entered, no write to addr 0 afterwards.
REQ-036 Reset during WRITE: rst_n low while imem_we=1 -> imem_we=0 immediately and state IDLE; a subsequent start reloads from addr 0.
REQ-037 Restart: start pulsed in DONE -> cpu_run=0 the next cycle, imem_addr=0, err=0.
